t5_dmem: RTL and testbench

Data-bus initiator for the t5 pipeline. In the execute stage it turns a load or store into a single Wishbone-style data-bus cycle: word-aligned address, byte selects, lane-replicated store data, strobe and write-enable. It holds the pipeline until the cycle is acknowledged or times out. Its registered `dwb_sel`/`dwb_stb`/`dwb_wre` are the byte-select/strobe/write signals that the load-extension/writeback stage consumes as `xsel`/`xstb`/`xwre`.

---
 rtl/t5_pkg.sv | 16 +
 rtl/t5_dalign.sv | 38 +++
 rtl/t5_dmem.sv | 110 +++++++++++
 tb/tb_t5_dmem.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/t5_pkg.sv
// Shared t5 pipeline definitions: opcode/size encodings and the data-bus FSM state.
package t5_pkg;

  localparam logic [4:0] OPC_LOAD  = 5'h00;
  localparam logic [4:0] OPC_STORE = 5'h08;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } dstate_t;

endpackage

// File: rtl/t5_dalign.sv
// Byte-lane steering for data-bus accesses: byte selects, replicated store data
// and misalignment detection from access size and the low address bits.
module t5_dalign
  import t5_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      size,
  input  logic [1:0]      adr,
  input  logic [XLEN-1:0] dat,
  output logic [3:0]      sel,
  output logic [XLEN-1:0] dto,
  output logic            mis
);

  always_comb begin
    sel = 4'h0;
    dto = dat;
    mis = 1'b0;
    unique case (size)
      SZ_B: begin
        sel = 4'b0001 << adr;
        dto = {4{dat[7:0]}};
      end
      SZ_H: begin
        mis = adr[0];
        sel = adr[1] ? 4'hC : 4'h3;
        dto = {2{dat[15:0]}};
      end
      SZ_W: begin
        mis = |adr;
        sel = 4'hF;
      end
      default: mis = 1'b1;
    endcase
  end

endmodule

// File: rtl/t5_dmem.sv
// Execute-stage data-bus initiator: one Wishbone-style cycle per load/store,
// pipeline hold until ack, ack timeout and misalignment reporting.
module t5_dmem
  import t5_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int TMOW = 4
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            sena,
  input  logic [6:2]      xopc,
  input  logic [14:12]    xfn3,
  input  logic [XLEN-1:0] xadr,
  input  logic [XLEN-1:0] xdat,
  output logic [XLEN-1:0] dwb_adr,
  output logic [XLEN-1:0] dwb_dto,
  output logic [3:0]      dwb_sel,
  output logic            dwb_stb,
  output logic            dwb_wre,
  input  logic            dwb_ack,
  output logic            dstall,
  output logic            dmis,
  output logic            derr
);

  // Counter value in the last BUSY cycle before timeout; the increment at that
  // edge would reach all-ones, i.e. 2^TMOW-1 BUSY cycles have elapsed.
  localparam logic [TMOW-1:0] TMO_LAST = {{(TMOW-1){1'b1}}, 1'b0};

  dstate_t         state, state_nx;
  logic [TMOW-1:0] cnt;
  logic [3:0]      a_sel;
  logic [XLEN-1:0] a_dto;
  logic            a_mis;
  logic            memop, is_st, take, issue, misreq, tmo;
  logic            unused_fn3;

  assign unused_fn3 = xfn3[14];

  t5_dalign #(.XLEN(XLEN)) u_align (
    .size (xfn3[13:12]),
    .adr  (xadr[1:0]),
    .dat  (xdat),
    .sel  (a_sel),
    .dto  (a_dto),
    .mis  (a_mis)
  );

  assign is_st  = (xopc == OPC_STORE);
  assign memop  = (xopc == OPC_LOAD) || is_st;
  // A new request is only looked at in IDLE or in the ack cycle of BUSY.
  assign take   = (state == ST_IDLE) || dwb_ack;
  assign issue  = take && sena && memop && !a_mis;
  assign misreq = take && sena && memop && a_mis;
  assign tmo    = (state == ST_BUSY) && !dwb_ack && (cnt == TMO_LAST);

  always_ff @(posedge sclk) begin
    if (srst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (issue) state_nx = ST_BUSY;
      ST_BUSY: begin
        if (dwb_ack)  state_nx = issue ? ST_BUSY : ST_IDLE;
        else if (tmo) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    dstall = (state == ST_BUSY) && !dwb_ack;
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      dwb_adr <= '0;
      dwb_dto <= '0;
      dwb_sel <= 4'h0;
      dwb_stb <= 1'b0;
      dwb_wre <= 1'b0;
      dmis    <= 1'b0;
      derr    <= 1'b0;
      cnt     <= '0;
    end else begin
      dmis <= misreq;
      derr <= tmo;
      if (issue) begin
        dwb_adr <= {xadr[XLEN-1:2], 2'b00};
        dwb_sel <= a_sel;
        dwb_dto <= is_st ? a_dto : '0;
        dwb_stb <= 1'b1;
        dwb_wre <= is_st;
        cnt     <= '0;
      end else if (state == ST_BUSY) begin
        if (dwb_ack || tmo) begin
          dwb_stb <= 1'b0;
          dwb_wre <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_t5_dmem.sv
// Scoreboard bench for t5_dmem: expected bus cycles queued at issue, checked when stb starts a cycle.
module tb_t5_dmem;

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dto;
    logic        wre;
  } bus_t;

  logic        sclk = 1'b0;
  logic        srst = 1'b1;
  logic        sena = 1'b0;
  logic [6:2]  xopc = 5'h04;
  logic [14:12] xfn3 = 3'b000;
  logic [31:0] xadr = '0;
  logic [31:0] xdat = '0;
  logic [31:0] dwb_adr, dwb_dto;
  logic [3:0]  dwb_sel;
  logic        dwb_stb, dwb_wre, dwb_ack, dstall, dmis, derr;

  int checks = 0;
  int failures = 0;
  bus_t sb[$];

  always #5 sclk = ~sclk;

  t5_dmem #(.XLEN(32), .TMOW(4)) dut (
    .sclk(sclk), .srst(srst), .sena(sena), .xopc(xopc), .xfn3(xfn3),
    .xadr(xadr), .xdat(xdat), .dwb_adr(dwb_adr), .dwb_dto(dwb_dto),
    .dwb_sel(dwb_sel), .dwb_stb(dwb_stb), .dwb_wre(dwb_wre),
    .dwb_ack(dwb_ack), .dstall(dstall), .dmis(dmis), .derr(derr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // New bus cycle starts when stb appears, or stays high right after an ack.
  logic p_stb = 1'b0, p_ack = 1'b0;
  always @(negedge sclk) begin
    if (dwb_stb && (!p_stb || p_ack)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        bus_t e;
        e = sb.pop_front();
        chk("sb_adr", dwb_adr, e.adr);
        chk("sb_sel", dwb_sel, e.sel);
        chk("sb_dto", dwb_dto, e.dto);
        chk("sb_wre", dwb_wre, e.wre);
      end
    end
    p_stb = dwb_stb;
    p_ack = dwb_ack;
  end

  task automatic drive(input logic [4:0] opc, input logic [2:0] fn3,
                       input logic [31:0] adr, input logic [31:0] dat);
    sena = 1'b1; xopc = opc; xfn3 = fn3; xadr = adr; xdat = dat;
  endtask

  task automatic idle_in();
    sena = 1'b0; xopc = 5'h04;
  endtask

  // One request, `waits` no-ack BUSY cycles, then ack.
  task automatic do_req(input string tag, input logic [4:0] opc, input logic [2:0] fn3,
                        input logic [31:0] adr, input logic [31:0] dat, input int waits,
                        input bus_t e);
    int stalls = 0;
    drive(opc, fn3, adr, dat);
    sb.push_back(e);
    tick();
    idle_in();
    for (int k = 0; k < waits; k++) begin
      @(negedge sclk);
      if (dstall) stalls++;
      tick();
    end
    dwb_ack = 1'b1;
    @(negedge sclk);
    chk({tag, "_stall_ack"}, dstall, 0);
    chk({tag, "_stb_ack"}, dwb_stb, 1);
    tick();
    dwb_ack = 1'b0;
    @(negedge sclk);
    chk({tag, "_stb_drop"}, dwb_stb, 0);
    chk({tag, "_wre_drop"}, dwb_wre, 0);
    chk({tag, "_stalls"}, stalls, waits);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dwb_ack = 1'b0;
    tick(); tick();
    @(negedge sclk);
    chk("rst_adr", dwb_adr, 0);
    chk("rst_stb", dwb_stb, 0);
    chk("rst_sel", dwb_sel, 0);
    chk("rst_stall", dstall, 0);
    srst = 1'b0;
    tick();

    // sena=0 with a load present, and a stray ack in IDLE
    xopc = 5'h00; xfn3 = 3'b010; xadr = 32'h100; dwb_ack = 1'b1;
    tick();
    @(negedge sclk);
    chk("noena_stb", dwb_stb, 0);
    chk("idle_ack_stall", dstall, 0);
    dwb_ack = 1'b0;
    tick();

    do_req("sb", 5'h08, 3'b000, 32'h1003, 32'hAABBCCDD, 2, '{32'h1000, 4'h8, 32'hDDDDDDDD, 1'b1});
    do_req("lh", 5'h00, 3'b001, 32'h2002, 32'h12345678, 0, '{32'h2000, 4'hC, 32'h0, 1'b0});
    do_req("sh", 5'h08, 3'b101, 32'h2000, 32'h0000BEEF, 1, '{32'h2000, 4'h3, 32'hBEEFBEEF, 1'b1});

    // misaligned word load
    drive(5'h00, 3'b010, 32'h3001, 32'h0);
    tick();
    idle_in();
    @(negedge sclk);
    chk("mis_pulse", dmis, 1);
    chk("mis_stb", dwb_stb, 0);
    chk("mis_stall", dstall, 0);
    tick();
    @(negedge sclk);
    chk("mis_clear", dmis, 0);
    tick();
    // illegal size 11
    drive(5'h08, 3'b011, 32'h3000, 32'h0);
    tick();
    idle_in();
    @(negedge sclk);
    chk("ill_mis", dmis, 1);
    chk("ill_stb", dwb_stb, 0);
    tick();

    // back-to-back: store word 0x10, then load byte 0x15 in the ack cycle
    drive(5'h08, 3'b010, 32'h10, 32'h12345678);
    sb.push_back('{32'h10, 4'hF, 32'h12345678, 1'b1});
    tick();
    drive(5'h00, 3'b000, 32'h15, 32'hFFFFFFFF);
    dwb_ack = 1'b1;
    sb.push_back('{32'h14, 4'h2, 32'h0, 1'b0});
    @(negedge sclk);
    chk("b2b_stall", dstall, 0);
    tick();
    idle_in();
    dwb_ack = 1'b0;
    @(negedge sclk);
    chk("b2b_stb", dwb_stb, 1);
    chk("b2b_adr", dwb_adr, 32'h14);
    chk("b2b_sel", dwb_sel, 4'h2);
    chk("b2b_stall2", dstall, 1);
    tick();
    dwb_ack = 1'b1;
    tick();
    dwb_ack = 1'b0;
    @(negedge sclk);
    chk("b2b_end", dwb_stb, 0);
    tick();

    // timeout: no ack for 15 BUSY cycles
    drive(5'h00, 3'b010, 32'h40, 32'h0);
    sb.push_back('{32'h40, 4'hF, 32'h0, 1'b0});
    tick();
    idle_in();
    for (int k = 1; k <= 15; k++) begin
      @(negedge sclk);
      chk("tmo_stb_hold", dwb_stb, 1);
      chk("tmo_derr_early", derr, 0);
      tick();
    end
    @(negedge sclk);
    chk("tmo_stb", dwb_stb, 0);
    chk("tmo_derr", derr, 1);
    chk("tmo_stall", dstall, 0);
    tick();
    @(negedge sclk);
    chk("tmo_derr_pulse", derr, 0);
    tick();

    // ack on the 15th BUSY cycle wins over timeout
    drive(5'h08, 3'b010, 32'h44, 32'hCAFEF00D);
    sb.push_back('{32'h44, 4'hF, 32'hCAFEF00D, 1'b1});
    tick();
    idle_in();
    for (int k = 1; k <= 14; k++) tick();
    dwb_ack = 1'b1;
    tick();
    dwb_ack = 1'b0;
    @(negedge sclk);
    chk("ack15_derr", derr, 0);
    chk("ack15_stb", dwb_stb, 0);
    tick();

    // srst in the 2nd BUSY cycle, with an ack pending
    drive(5'h08, 3'b001, 32'h22, 32'h0000BEEF);
    sb.push_back('{32'h20, 4'hC, 32'hBEEFBEEF, 1'b1});
    tick();
    idle_in();
    tick();
    srst = 1'b1; dwb_ack = 1'b1;
    tick();
    srst = 1'b0; dwb_ack = 1'b0;
    @(negedge sclk);
    chk("srst_stb", dwb_stb, 0);
    chk("srst_adr", dwb_adr, 0);
    chk("srst_dto", dwb_dto, 0);
    chk("srst_sel", dwb_sel, 0);
    chk("srst_wre", dwb_wre, 0);
    chk("srst_stall", dstall, 0);
    chk("srst_flags", {dmis, derr}, 0);
    tick();
    do_req("post_rst", 5'h00, 3'b100, 32'h7, 32'h0, 1, '{32'h4, 4'h8, 32'h0, 1'b0});

    tick();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
